ex_mem_skid: RTL and testbench

//  Pipeline boundary between the execute stage (ALU result, zeroFlag, store data, dest reg, ctrl)
//  and the memory stage. Two-entry skid buffer with valid/ready handshake on both sides, so MEM
//  can stall without a combinational ready path back into EX. Resolves branch-taken (branch & zero),
//  and suppresses register writes to $zero.

---
 rtl/ex_mem_pkg.sv | 48 ++++
 rtl/ex_mem_skid_if.sv | 49 ++++
 rtl/ex_mem_slot.sv | 23 ++
 rtl/ex_mem_skid.sv | 132 +++++++++++++
 tb/tb_ex_mem_skid.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline boundary: the payload record, its width,
// the skid-buffer occupancy states and the capture helper used at entry.
package ex_mem_pkg;

  localparam int EXM_DW = 32;
  localparam int EXM_RW = 5;

  typedef struct packed {
    logic [EXM_DW-1:0] result;
    logic [EXM_DW-1:0] storeData;
    logic [EXM_RW-1:0] rd;
    logic              memRead;
    logic              memWrite;
    logic              regWrite;
    logic              branchTaken;
  } exm_payload_t;

  localparam int EXM_PAYLOAD_W = $bits(exm_payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } exm_state_t;

  // Writes to $zero are dropped here so downstream never needs to re-check rd.
  function automatic exm_payload_t exm_capture(
    input logic [EXM_DW-1:0] result,
    input logic              zero,
    input logic [EXM_DW-1:0] store_data,
    input logic [EXM_RW-1:0] rd,
    input logic              mem_read,
    input logic              mem_write,
    input logic              reg_write,
    input logic              branch
  );
    exm_payload_t p;
    p.result      = result;
    p.storeData   = store_data;
    p.rd          = rd;
    p.memRead     = mem_read;
    p.memWrite    = mem_write;
    p.regWrite    = reg_write & (rd != '0);
    p.branchTaken = branch & zero;
    return p;
  endfunction

endpackage

// File: rtl/ex_mem_skid_if.sv
// EX/MEM boundary bundle: EX-side handshake and payload, MEM-side handshake and
// payload, plus the forwarding tap. slave = buffer view, master = surrounding pipeline.
interface ex_mem_skid_if #(
  parameter int DW = 32,
  parameter int RW = 5
);

  logic          exValid;
  logic          exReady;
  logic [DW-1:0] exResult;
  logic          exZero;
  logic [DW-1:0] exStoreData;
  logic [RW-1:0] exRd;
  logic          exMemRead;
  logic          exMemWrite;
  logic          exRegWrite;
  logic          exBranch;

  logic          memValid;
  logic          memReady;
  logic [DW-1:0] memResult;
  logic [DW-1:0] memStoreData;
  logic [RW-1:0] memRd;
  logic          memMemRead;
  logic          memMemWrite;
  logic          memRegWrite;
  logic          memBranchTaken;

  logic          fwdValid;
  logic [RW-1:0] fwdRd;
  logic [DW-1:0] fwdResult;

  modport slave (
    input  exValid, exResult, exZero, exStoreData, exRd,
           exMemRead, exMemWrite, exRegWrite, exBranch, memReady,
    output exReady, memValid, memResult, memStoreData, memRd,
           memMemRead, memMemWrite, memRegWrite, memBranchTaken,
           fwdValid, fwdRd, fwdResult
  );

  modport master (
    output exValid, exResult, exZero, exStoreData, exRd,
           exMemRead, exMemWrite, exRegWrite, exBranch, memReady,
    input  exReady, memValid, memResult, memStoreData, memRd,
           memMemRead, memMemWrite, memRegWrite, memBranchTaken,
           fwdValid, fwdRd, fwdResult
  );

endinterface

// File: rtl/ex_mem_slot.sv
// One payload register of the skid buffer (used for both OUT and SKID entries):
// loads on enable, clears asynchronously.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the payload is cleared on reset (not just the valid bit) so every
  // mem* output reads zero straight out of reset; flush only clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM two-entry skid buffer: registered exReady, ordered OUT/SKID entries,
// branch resolution and $zero write suppression at capture.
// Optional forwarding tap enabled by defining EX_MEM_FWD_EN.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int DW = EXM_DW,
  parameter int RW = EXM_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ex_mem_skid_if.slave  bus
);

  localparam int PAYLOAD_W = 2 * DW + RW + 4;

  exm_state_t   state_q;
  exm_state_t   state_d;
  logic         ex_ready_q;
  logic         mem_valid_q;
  logic         accept;
  logic         load_out;
  logic         load_skid;
  logic         out_from_skid;
  exm_payload_t in_payload;
  exm_payload_t out_d;
  exm_payload_t out_q;
  exm_payload_t skid_q;

  assign accept = bus.exValid & ex_ready_q;

  assign in_payload = exm_capture(bus.exResult, bus.exZero, bus.exStoreData, bus.exRd,
                                  bus.exMemRead, bus.exMemWrite, bus.exRegWrite,
                                  bus.exBranch);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      // Accepted payload this cycle is dropped; stale data may remain in the slots.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            load_out = 1'b1;
          end
        end
        ONE: begin
          if (accept && bus.memReady) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (bus.memReady) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (bus.memReady) begin
            state_d       = ONE;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign out_d = out_from_skid ? skid_q : in_payload;

  // exReady and memValid are their own flops so neither has a combinational
  // path from memReady or from state decoding.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= (state_d != FULL);
      mem_valid_q <= (state_d != EMPTY);
    end
  end

  ex_mem_slot #(.W(PAYLOAD_W)) u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_out),
    .d     (out_d),
    .q     (out_q)
  );

  ex_mem_slot #(.W(PAYLOAD_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_skid),
    .d     (in_payload),
    .q     (skid_q)
  );

  assign bus.exReady        = ex_ready_q;
  assign bus.memValid       = mem_valid_q;
  assign bus.memResult      = out_q.result;
  assign bus.memStoreData   = out_q.storeData;
  assign bus.memRd          = out_q.rd;
  assign bus.memMemRead     = out_q.memRead;
  assign bus.memMemWrite    = out_q.memWrite;
  assign bus.memRegWrite    = out_q.regWrite;
  assign bus.memBranchTaken = out_q.branchTaken;

`ifdef EX_MEM_FWD_EN
  // Loads never forward: their result is an address, not the loaded value.
  assign bus.fwdValid  = mem_valid_q & out_q.regWrite & ~out_q.memRead;
  assign bus.fwdRd     = out_q.rd;
  assign bus.fwdResult = out_q.result;
`else
  assign bus.fwdValid  = 1'b0;
  assign bus.fwdRd     = '0;
  assign bus.fwdResult = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: table-driven stream vectors plus hand-written stall,
// flush and async-reset sequences, with an in-order scoreboard on the MEM side.
module tb_ex_mem_skid;
  import ex_mem_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        br;
    logic        exp_rw;
    logic        exp_bt;
    logic        exp_fwd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exm_payload_t sb[$];
  exm_payload_t cur_exp;
  vec_t         vecs[10];

  ex_mem_skid_if #(.DW(32), .RW(5)) bus ();

  ex_mem_skid #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.exValid     = 1'b1;
    bus.exResult    = v.result;
    bus.exZero      = v.zero;
    bus.exStoreData = v.store;
    bus.exRd        = v.rd;
    bus.exMemRead   = v.mr;
    bus.exMemWrite  = v.mw;
    bus.exRegWrite  = v.rw;
    bus.exBranch    = v.br;
    cur_exp.result      = v.result;
    cur_exp.storeData   = v.store;
    cur_exp.rd          = v.rd;
    cur_exp.memRead     = v.mr;
    cur_exp.memWrite    = v.mw;
    cur_exp.regWrite    = v.exp_rw;
    cur_exp.branchTaken = v.exp_bt;
  endtask

  task automatic idle();
    bus.exValid = 1'b0;
  endtask

  function automatic vec_t alu(input logic [31:0] r, input logic [4:0] rd);
    return '{r, 1'b0, 32'h0, rd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  endfunction

  // Scoreboard: push on EX handshake, pop/compare on MEM handshake; sampled on
  // the falling edge, half a cycle away from the capturing edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (bus.memValid && bus.memReady) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_emit", 128'(bus.memResult), 128'hx);
        end else begin
          exm_payload_t a;
          exm_payload_t e;
          e = sb.pop_front();
          a.result      = bus.memResult;
          a.storeData   = bus.memStoreData;
          a.rd          = bus.memRd;
          a.memRead     = bus.memMemRead;
          a.memWrite    = bus.memMemWrite;
          a.regWrite    = bus.memRegWrite;
          a.branchTaken = bus.memBranchTaken;
          check("sb_payload", 128'(a), 128'(e));
        end
      end
      if (bus.exValid && bus.exReady) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic exp_fwd;
    // result, zero, store, rd, mr, mw, rw, br | exp_rw, exp_bt, exp_fwd
    vecs[0] = '{32'h1,      1'b0, 32'h0,        5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h2,      1'b0, 32'h0,        5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h3,      1'b0, 32'h0,        5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h44,     1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h55,     1'b0, 32'h0,        5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h0,      1'b1, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h7,      1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h88,     1'b0, 32'h0,        5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'h1000,   1'b0, 32'h0,        5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{32'h2000,   1'b0, 32'hdeadbeef, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    drive(vecs[0]);
    idle();
    bus.memReady = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    check("rst_memValid",  128'(bus.memValid),    128'(0));
    check("rst_exReady",   128'(bus.exReady),     128'(1));
    check("rst_memResult", 128'(bus.memResult),   128'(0));
    check("rst_regWrite",  128'(bus.memRegWrite), 128'(0));
    check("rst_fwdValid",  128'(bus.fwdValid),    128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();

    // Stream: one-cycle latency, never full
    bus.memReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
`ifdef EX_MEM_FWD_EN
      exp_fwd = v.exp_fwd;
`else
      exp_fwd = 1'b0;
`endif
      drive(v);
      step();
      check("stream_memValid",  128'(bus.memValid),       128'(1));
      check("stream_memResult", 128'(bus.memResult),      128'(v.result));
      check("stream_regWrite",  128'(bus.memRegWrite),    128'(v.exp_rw));
      check("stream_branch",    128'(bus.memBranchTaken), 128'(v.exp_bt));
      check("stream_fwdValid",  128'(bus.fwdValid),       128'(exp_fwd));
      check("stream_exReady",   128'(bus.exReady),        128'(1));
`ifdef EX_MEM_FWD_EN
      if (exp_fwd) check("stream_fwdRd", 128'(bus.fwdRd), 128'(v.rd));
`endif
    end
    idle();
    step();
    check("stream_drain", 128'(bus.memValid), 128'(0));

    // Stall: A then B with MEM stalled, then release
    bus.memReady = 1'b0;
    drive(alu(32'h10, 5'd4));
    step();
    check("stall_exReady_one", 128'(bus.exReady),   128'(1));
    check("stall_result_a",    128'(bus.memResult), 128'(32'h10));
    drive(alu(32'h20, 5'd6));
    step();
    check("stall_exReady_full", 128'(bus.exReady),   128'(0));
    check("stall_hold_a",       128'(bus.memResult), 128'(32'h10));
    drive(alu(32'h30, 5'd7));
    step();
    check("stall_hold_a2",      128'(bus.memResult), 128'(32'h10));
    check("stall_exReady_hold", 128'(bus.exReady),   128'(0));
    bus.memReady = 1'b1;
    step();
    check("stall_result_b",    128'(bus.memResult), 128'(32'h20));
    check("stall_exReady_back", 128'(bus.exReady),  128'(1));
    step();
    check("stall_result_c", 128'(bus.memResult), 128'(32'h30));
    idle();
    step();
    check("stall_drain", 128'(bus.memValid), 128'(0));

    // Flush while FULL with EX still presenting
    bus.memReady = 1'b0;
    drive(alu(32'h40, 5'd10));
    step();
    drive(alu(32'h50, 5'd11));
    step();
    check("flush_pre_full", 128'(bus.exReady), 128'(0));
    drive(alu(32'h60, 5'd12));
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("flush_memValid", 128'(bus.memValid), 128'(0));
    check("flush_exReady",  128'(bus.exReady),  128'(1));
    bus.memReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_stale", 128'(bus.memValid), 128'(0));
    end

    // Flush wins over a simultaneous accept
    drive(alu(32'h70, 5'd13));
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("flush_wins", 128'(bus.memValid), 128'(0));
    step();
    check("flush_wins_later", 128'(bus.memValid), 128'(0));

    // Async reset in the middle of a stall
    bus.memReady = 1'b0;
    drive(alu(32'h80, 5'd14));
    step();
    drive(alu(32'h90, 5'd15));
    step();
    check("arst_pre_full", 128'(bus.exReady), 128'(0));
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_memValid",  128'(bus.memValid),  128'(0));
    check("arst_exReady",   128'(bus.exReady),   128'(1));
    check("arst_memResult", 128'(bus.memResult), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    bus.memReady = 1'b1;
    step();
    check("arst_after", 128'(bus.memValid), 128'(0));

    step();
    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
